sip_round_sequencer: RTL and testbench

SIP_ROUND_SEQUENCER -- requirements
Module: sip_round_sequencer

---
 rtl/sip_round_sequencer.sv | 133 +++++++++++++
 tb/tb_sip_round_sequencer.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/sip_round_sequencer.sv
// Control sequencer for a SipHash-c-d core: steers init, message absorption,
// compression/finalization rounds and the done pulse for an external datapath.
module sip_round_sequencer #(
  parameter int unsigned C_ROUNDS = 2,
  parameter int unsigned D_ROUNDS = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       msg_valid,
  input  logic       msg_last,
  input  logic [2:0] msg_bytes,
  output logic       msg_ready,
  output logic       init_load,
  output logic       xor_m_pre,
  output logic       round_en,
  output logic       xor_m_post,
  output logic       xor_ff,
  output logic [7:0] len_byte,
  output logic       done,
  output logic       busy
);

  typedef enum logic [2:0] {
    StIdle,
    StInit,
    StWaitM,
    StComp,
    StPost,
    StFinXor,
    StFinal,
    StDone
  } state_e;

  state_e     state_q, state_d;
  logic [7:0] byte_cnt_q, byte_cnt_d;
  logic       last_q, last_d;
  logic [3:0] cnt_q, cnt_d;
  logic       xfer;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      byte_cnt_q <= '0;
      last_q     <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      byte_cnt_q <= byte_cnt_d;
      last_q     <= last_d;
      cnt_q      <= cnt_d;
    end
  end

  assign xfer = msg_valid && (state_q == StWaitM);

  always_comb begin
    state_d    = state_q;
    byte_cnt_d = byte_cnt_q;
    last_d     = last_q;
    cnt_d      = cnt_q;
    msg_ready  = 1'b0;
    init_load  = 1'b0;
    xor_m_pre  = 1'b0;
    round_en   = 1'b0;
    xor_m_post = 1'b0;
    xor_ff     = 1'b0;
    done       = 1'b0;
    busy       = (state_q != StIdle);

    unique case (state_q)
      StIdle: begin
        if (start) state_d = StInit;
      end
      StInit: begin
        init_load  = 1'b1;
        byte_cnt_d = '0;
        last_d     = 1'b0;
        state_d    = StWaitM;
      end
      StWaitM: begin
        msg_ready = 1'b1;
        if (xfer) begin
          xor_m_pre = 1'b1;
          last_d    = msg_last;
          // Length byte counts only full words; the last word's bytes add in len_byte.
          if (!msg_last) byte_cnt_d = byte_cnt_q + 8'd8;
          cnt_d     = 4'(C_ROUNDS - 1);
          state_d   = StComp;
        end
      end
      StComp: begin
        round_en = 1'b1;
        if (cnt_q == 4'd0) state_d = StPost;
        else               cnt_d   = cnt_q - 4'd1;
      end
      StPost: begin
        xor_m_post = 1'b1;
        state_d    = last_q ? StFinXor : StWaitM;
      end
      StFinXor: begin
        xor_ff  = 1'b1;
        cnt_d   = 4'(D_ROUNDS - 1);
        state_d = StFinal;
      end
      StFinal: begin
        round_en = 1'b1;
        if (cnt_q == 4'd0) state_d = StDone;
        else               cnt_d   = cnt_q - 4'd1;
      end
      StDone: begin
        done    = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // Keep the datapath quiet for the whole reset cycle, not just after the edge.
    if (rst) begin
      msg_ready  = 1'b0;
      init_load  = 1'b0;
      xor_m_pre  = 1'b0;
      round_en   = 1'b0;
      xor_m_post = 1'b0;
      xor_ff     = 1'b0;
      done       = 1'b0;
      busy       = 1'b0;
    end
  end

  assign len_byte = rst ? {5'b0, msg_bytes} : byte_cnt_q + {5'b0, msg_bytes};

endmodule

// File: tb/tb_sip_round_sequencer.sv
// Randomized bench: each hash is described as a list of words with upstream gaps and
// expanded into an expected per-cycle strobe trace, then compared cycle by cycle.
module tb_sip_round_sequencer;

  localparam int C = 2;
  localparam int D = 4;

  // Strobe vector bit positions: {ready, init, pre, round, post, ff, done}
  localparam logic [6:0] S_READY = 7'b1000000;
  localparam logic [6:0] S_INIT  = 7'b0100000;
  localparam logic [6:0] S_PRE   = 7'b0010000;
  localparam logic [6:0] S_ROUND = 7'b0001000;
  localparam logic [6:0] S_POST  = 7'b0000100;
  localparam logic [6:0] S_FF    = 7'b0000010;
  localparam logic [6:0] S_DONE  = 7'b0000001;

  logic       clk = 1'b0;
  logic       rst, start, msg_valid, msg_last;
  logic [2:0] msg_bytes;
  logic       msg_ready, init_load, xor_m_pre, round_en, xor_m_post, xor_ff, done, busy;
  logic [7:0] len_byte;
  logic [6:0] outs;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct packed {
    logic [6:0] strb;
    logic       busy;
    logic       xfer;
    logic       last;
  } step_t;

  sip_round_sequencer #(
    .C_ROUNDS(C),
    .D_ROUNDS(D)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .msg_valid (msg_valid),
    .msg_last  (msg_last),
    .msg_bytes (msg_bytes),
    .msg_ready (msg_ready),
    .init_load (init_load),
    .xor_m_pre (xor_m_pre),
    .round_en  (round_en),
    .xor_m_post(xor_m_post),
    .xor_ff    (xor_ff),
    .len_byte  (len_byte),
    .done      (done),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  assign outs = {msg_ready, init_load, xor_m_pre, round_en, xor_m_post, xor_ff, done};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got 0x%0h expected 0x%0h", tag, $time, got, exp);
    end
  endtask

  function automatic step_t mk(input logic [6:0] strb, input logic bsy, input logic xf,
                               input logic lst);
    step_t s;
    s.strb = strb;
    s.busy = bsy;
    s.xfer = xf;
    s.last = lst;
    return s;
  endfunction

  // n words (last one carries last_bytes); gap < 0 means random 0..3 idle cycles per word.
  // abort >= 0 asserts rst at that trace index instead of checking it.
  task automatic run_hash(input int n, input int last_bytes, input int gap, input int abort);
    step_t q[$];
    int    g;
    int    exp_len;
    q.push_back(mk(7'b0, 1'b0, 1'b0, 1'b0));
    q.push_back(mk(S_INIT, 1'b1, 1'b0, 1'b0));
    for (int w = 0; w < n; w++) begin
      g = (gap < 0) ? int'($urandom_range(0, 3)) : gap;
      for (int k = 0; k < g; k++) q.push_back(mk(S_READY, 1'b1, 1'b0, 1'b0));
      q.push_back(mk(S_READY | S_PRE, 1'b1, 1'b1, w == n - 1));
      for (int k = 0; k < C; k++) q.push_back(mk(S_ROUND, 1'b1, 1'b0, 1'b0));
      q.push_back(mk(S_POST, 1'b1, 1'b0, 1'b0));
    end
    q.push_back(mk(S_FF, 1'b1, 1'b0, 1'b0));
    for (int k = 0; k < D; k++) q.push_back(mk(S_ROUND, 1'b1, 1'b0, 1'b0));
    q.push_back(mk(S_DONE, 1'b1, 1'b0, 1'b0));
    exp_len = (8 * (n - 1) + last_bytes) % 256;

    for (int i = 0; i < q.size(); i++) begin
      @(negedge clk);
      rst   = (i == abort);
      start = (i == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      if (q[i].xfer) begin
        msg_valid = 1'b1;
        msg_last  = q[i].last;
        msg_bytes = q[i].last ? 3'(last_bytes) : 3'($urandom_range(0, 7));
      end else if (q[i].strb[6]) begin
        msg_valid = 1'b0;
        msg_last  = 1'($urandom_range(0, 1));
        msg_bytes = 3'($urandom_range(0, 7));
      end else begin
        // Words offered outside the accept window must be ignored.
        msg_valid = 1'($urandom_range(0, 1));
        msg_last  = 1'($urandom_range(0, 1));
        msg_bytes = 3'($urandom_range(0, 7));
      end
      #1;
      if (i == abort) begin
        check("abort_strobes", 32'(outs), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_len", 32'(len_byte), 32'(msg_bytes));
        break;
      end
      check("strobes", 32'(outs), 32'(q[i].strb));
      check("busy", 32'(busy), 32'(q[i].busy));
      if (q[i].xfer && q[i].last) check("len_byte", 32'(len_byte), 32'(exp_len));
    end

    @(negedge clk);
    rst       = 1'b0;
    start     = 1'b0;
    msg_valid = 1'($urandom_range(0, 1));
    msg_last  = 1'($urandom_range(0, 1));
    msg_bytes = 3'($urandom_range(0, 7));
    #1;
    check("idle_strobes", 32'(outs), 32'd0);
    check("idle_busy", 32'(busy), 32'd0);
  endtask

  initial begin
    rst       = 1'b1;
    start     = 1'b1;
    msg_valid = 1'b1;
    msg_last  = 1'b1;
    msg_bytes = 3'd5;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      msg_bytes = 3'(i + 2);
      #1;
      check("reset_strobes", 32'(outs), 32'd0);
      check("reset_busy", 32'(busy), 32'd0);
      check("reset_len", 32'(len_byte), 32'(msg_bytes));
    end
    @(negedge clk);
    rst       = 1'b0;
    start     = 1'b0;
    msg_valid = 1'b0;
    msg_bytes = 3'd6;
    #1;
    check("post_reset_strobes", 32'(outs), 32'd0);
    check("post_reset_len", 32'(len_byte), 32'd6);

    run_hash(1, 0, 0, -1);          // empty message
    run_hash(3, 5, 0, -1);          // two full words + 5 bytes
    run_hash(2, 7, 3, -1);          // three-cycle upstream gaps
    run_hash(34, 3, 0, -1);         // length byte wraps
    run_hash(2, 4, 0, 2 + 2 * (C + 2) + 1 + 2);  // reset lands in finalization rounds
    run_hash(1, 1, 0, -1);          // restart right after the abort
    for (int r = 0; r < 20; r++)
      run_hash(int'($urandom_range(1, 5)), int'($urandom_range(0, 7)), -1, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

endmodule
